// File: rtl/hps_fabric_reset_sequencer.sv
// Top-level SoC reset sequencer: holds Platform Designer in reset until configuration is done,
// then releases the fabric once the HPS lets go of h2f_reset. Handles warm resets, software pulses and boot timeouts.
//
// state    | meaning
// CONFIG   | device configuration not done, everything held in reset
// HOLD     | configuration done, qsys_reset_n held low for HOLD_CYCLES
// WAIT_HPS | system running, waiting for a debounced h2f_reset release
// RUN      | fabric released
// SW_RST   | software-requested fabric reset pulse
// FAULT    | HPS boot timeout, LEDs blink until ninit or block reset
module hps_fabric_reset_sequencer #(
    parameter int HOLD_CYCLES     = 1024,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 100000000,
    parameter int SW_PULSE_CYCLES = 32,
    parameter int BLINK_CYCLES    = 25000000
) (
    input  logic       clk_100_clk,
    input  logic       reset_reset,
    input  logic       ninit_done_ninit_done,
    input  logic       h2f_reset_reset,
    input  logic       sw_reset_req,
    output logic       qsys_reset_n,
    output logic       fabric_reset,
    output logic       fault,
    output logic [1:0] status_led,
    output logic [2:0] seq_state
);

    localparam logic [2:0] ST_CONFIG = 3'd0;
    localparam logic [2:0] ST_HOLD   = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_RUN    = 3'd3;
    localparam logic [2:0] ST_SW_RST = 3'd4;
    localparam logic [2:0] ST_FAULT  = 3'd5;

    localparam int CNT_MAX = (HOLD_CYCLES > SW_PULSE_CYCLES) ? HOLD_CYCLES : SW_PULSE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BLK_W   = $clog2(BLINK_CYCLES + 1);

    logic             ninit_meta_q, ninit_meta_d, ninit_s_q, ninit_s_d;
    logic             h2f_meta_q, h2f_meta_d, h2f_s_q, h2f_s_d;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d, tmo_inc;
    logic [DEB_W-1:0] deb_q, deb_d, deb_inc;
    logic [BLK_W-1:0] blink_q, blink_d;
    logic             blink_toggle;
    logic             qsys_reset_n_q, qsys_reset_n_d;
    logic             fabric_reset_q, fabric_reset_d;
    logic             fault_q, fault_d;
    logic [1:0]       status_led_q, status_led_d;

    assign ninit_meta_d = ninit_done_ninit_done;
    assign ninit_s_d    = ninit_meta_q;
    assign h2f_meta_d   = h2f_reset_reset;
    assign h2f_s_d      = h2f_meta_q;

    assign tmo_inc = (tmo_q == TMO_W'(TIMEOUT_CYCLES)) ? tmo_q : tmo_q + TMO_W'(1);
    assign deb_inc = (deb_q == DEB_W'(DEBOUNCE_CYCLES)) ? deb_q : deb_q + DEB_W'(1);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tmo_d        = '0;
        deb_d        = '0;
        blink_d      = '0;
        blink_toggle = 1'b0;

        if (ninit_s_q && (state_q != ST_CONFIG)) begin
            state_d = ST_CONFIG;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_CONFIG: begin
                    if (!ninit_s_q) begin
                        state_d = ST_HOLD;
                        cnt_d   = CNT_W'(HOLD_CYCLES - 1);
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == '0) state_d = ST_WAIT;
                    else             cnt_d   = cnt_q - CNT_W'(1);
                end
                ST_WAIT: begin
                    tmo_d = tmo_inc;
                    deb_d = h2f_s_q ? '0 : deb_inc;
                    // Debounce completion takes priority over a coincident timeout.
                    if (!h2f_s_q && (deb_inc == DEB_W'(DEBOUNCE_CYCLES)))
                        state_d = ST_RUN;
                    else if (tmo_inc == TMO_W'(TIMEOUT_CYCLES))
                        state_d = ST_FAULT;
                end
                ST_RUN: begin
                    if (h2f_s_q) begin
                        state_d = ST_WAIT;
                        cnt_d   = '0;
                    end else if (sw_reset_req) begin
                        state_d = ST_SW_RST;
                        cnt_d   = CNT_W'(SW_PULSE_CYCLES - 1);
                    end
                end
                ST_SW_RST: begin
                    if (h2f_s_q) begin
                        state_d = ST_WAIT;
                        cnt_d   = '0;
                    end else if (cnt_q == '0) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_FAULT: begin
                    if (blink_q == BLK_W'(BLINK_CYCLES - 1)) blink_toggle = 1'b1;
                    else                                     blink_d      = blink_q + BLK_W'(1);
                end
                default: begin
                    state_d = ST_CONFIG;
                    cnt_d   = '0;
                end
            endcase
        end

        // Timeout/debounce/blink counters only live inside their own state.
        if (state_d != ST_WAIT) begin
            tmo_d = '0;
            deb_d = '0;
        end
        if (state_d != ST_FAULT) blink_d = '0;
    end

    always_comb begin
        qsys_reset_n_d = !((state_d == ST_CONFIG) || (state_d == ST_HOLD));
        fabric_reset_d = (state_d != ST_RUN);
        fault_d        = (state_d == ST_FAULT);
        case (state_d)
            ST_WAIT:   status_led_d = 2'b01;
            ST_RUN:    status_led_d = 2'b10;
            ST_SW_RST: status_led_d = 2'b11;
            ST_FAULT: begin
                if (state_q != ST_FAULT) status_led_d = 2'b11;
                else if (blink_toggle)   status_led_d = ~status_led_q;
                else                     status_led_d = status_led_q;
            end
            default:   status_led_d = 2'b00;
        endcase
    end

    always_ff @(posedge clk_100_clk) begin
        if (reset_reset) begin
            ninit_meta_q   <= 1'b1;
            ninit_s_q      <= 1'b1;
            h2f_meta_q     <= 1'b1;
            h2f_s_q        <= 1'b1;
            state_q        <= ST_CONFIG;
            cnt_q          <= '0;
            tmo_q          <= '0;
            deb_q          <= '0;
            blink_q        <= '0;
            qsys_reset_n_q <= 1'b0;
            fabric_reset_q <= 1'b1;
            fault_q        <= 1'b0;
            status_led_q   <= 2'b00;
        end else begin
            ninit_meta_q   <= ninit_meta_d;
            ninit_s_q      <= ninit_s_d;
            h2f_meta_q     <= h2f_meta_d;
            h2f_s_q        <= h2f_s_d;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            tmo_q          <= tmo_d;
            deb_q          <= deb_d;
            blink_q        <= blink_d;
            qsys_reset_n_q <= qsys_reset_n_d;
            fabric_reset_q <= fabric_reset_d;
            fault_q        <= fault_d;
            status_led_q   <= status_led_d;
        end
    end

    assign qsys_reset_n = qsys_reset_n_q;
    assign fabric_reset = fabric_reset_q;
    assign fault        = fault_q;
    assign status_led   = status_led_q;
    assign seq_state    = state_q;

endmodule

// File: tb/tb_hps_fabric_reset_sequencer.sv
// Directed bench for hps_fabric_reset_sequencer with small parameters:
// HOLD=8, DEBOUNCE=4, TIMEOUT=64, SW_PULSE=5, BLINK=4.
module tb_hps_fabric_reset_sequencer;

    logic       clk_100_clk = 1'b0;
    logic       reset_reset;
    logic       ninit_done_ninit_done;
    logic       h2f_reset_reset;
    logic       sw_reset_req;
    logic       qsys_reset_n;
    logic       fabric_reset;
    logic       fault;
    logic [1:0] status_led;
    logic [2:0] seq_state;

    int n_chk  = 0;
    int n_pass = 0;
    int n;

    hps_fabric_reset_sequencer #(
        .HOLD_CYCLES    (8),
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_CYCLES (64),
        .SW_PULSE_CYCLES(5),
        .BLINK_CYCLES   (4)
    ) dut (
        .clk_100_clk          (clk_100_clk),
        .reset_reset          (reset_reset),
        .ninit_done_ninit_done(ninit_done_ninit_done),
        .h2f_reset_reset      (h2f_reset_reset),
        .sw_reset_req         (sw_reset_req),
        .qsys_reset_n         (qsys_reset_n),
        .fabric_reset         (fabric_reset),
        .fault                (fault),
        .status_led           (status_led),
        .seq_state            (seq_state)
    );

    always #5 clk_100_clk = ~clk_100_clk;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk_100_clk);
        #1;
    endtask

    // Advance until seq_state == st, returning cycles taken (budget on expiry).
    task automatic wait_state(input logic [2:0] st, input int budget, output int cycles);
        cycles = 0;
        do begin
            cyc();
            cycles++;
        end while ((seq_state != st) && (cycles < budget));
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_state"}, seq_state, 0);
        check_eq({tag, "_qsys"}, qsys_reset_n, 0);
        check_eq({tag, "_fab"}, fabric_reset, 1);
        check_eq({tag, "_fault"}, fault, 0);
        check_eq({tag, "_led"}, status_led, 0);
    endtask

    initial begin
        reset_reset           = 1'b1;
        ninit_done_ninit_done = 1'b1;
        h2f_reset_reset       = 1'b1;
        sw_reset_req          = 1'b0;
        repeat (3) cyc();
        check_reset_vals("por");
        reset_reset = 1'b0;

        // Power-up
        h2f_reset_reset = 1'b0;
        repeat (20) cyc();
        check_eq("cfg_hold_state", seq_state, 0);
        ninit_done_ninit_done = 1'b0;
        repeat (2) cyc();
        check_eq("cfg_sync_lat", seq_state, 0);
        cyc();
        check_eq("hold_entry", seq_state, 1);
        check_eq("hold_qsys", qsys_reset_n, 0);
        repeat (7) cyc();
        check_eq("hold_last", seq_state, 1);
        check_eq("hold_last_qsys", qsys_reset_n, 0);
        cyc();
        check_eq("wait_entry", seq_state, 2);
        check_eq("wait_qsys", qsys_reset_n, 1);
        check_eq("wait_led", status_led, 1);
        check_eq("wait_fab", fabric_reset, 1);
        repeat (3) cyc();
        check_eq("deb_pending", seq_state, 2);
        cyc();
        check_eq("run_entry", seq_state, 3);
        check_eq("run_fab", fabric_reset, 0);
        check_eq("run_led", status_led, 2);

        // Software reset, with a second request ignored mid-pulse
        for (int p = 0; p < 2; p++) begin
            sw_reset_req = 1'b1;
            cyc();
            sw_reset_req = 1'b0;
            check_eq("sw_state", seq_state, 4);
            check_eq("sw_led", status_led, 3);
            n = 1;
            for (int i = 0; i < 20; i++) begin
                if (p == 1 && i == 1) sw_reset_req = 1'b1;
                cyc();
                sw_reset_req = 1'b0;
                if (fabric_reset) n++;
                else break;
            end
            check_eq("sw_width", n, 5);
            check_eq("sw_back_run", seq_state, 3);
        end

        // HPS warm reset in RUN
        h2f_reset_reset = 1'b1;
        repeat (2) cyc();
        check_eq("warm_run_sync", seq_state, 3);
        cyc();
        check_eq("warm_run_wait", seq_state, 2);
        check_eq("warm_run_fab", fabric_reset, 1);
        check_eq("warm_run_qsys", qsys_reset_n, 1);
        h2f_reset_reset = 1'b0;
        wait_state(3'd3, 30, n);
        check_eq("warm_run_release", n, 6);

        // HPS warm reset in SW_RST overrides the pulse count
        sw_reset_req = 1'b1;
        cyc();
        sw_reset_req    = 1'b0;
        h2f_reset_reset = 1'b1;
        repeat (2) cyc();
        check_eq("warm_sw_sync", seq_state, 4);
        cyc();
        check_eq("warm_sw_wait", seq_state, 2);
        check_eq("warm_sw_qsys", qsys_reset_n, 1);
        h2f_reset_reset = 1'b0;
        wait_state(3'd3, 30, n);
        check_eq("warm_sw_release", n, 6);

        // Boot delay with a glitch restarting the debounce
        h2f_reset_reset = 1'b1;
        repeat (3) cyc();
        check_eq("glitch_wait", seq_state, 2);
        repeat (30) cyc();
        h2f_reset_reset = 1'b0;
        cyc();
        h2f_reset_reset = 1'b1;
        repeat (2) cyc();
        h2f_reset_reset = 1'b0;
        wait_state(3'd3, 30, n);
        check_eq("glitch_release", n, 6);
        check_eq("glitch_fault", fault, 0);

        // Timeout into FAULT
        h2f_reset_reset = 1'b1;
        repeat (3) cyc();
        check_eq("tmo_wait", seq_state, 2);
        repeat (63) cyc();
        check_eq("tmo_edge", seq_state, 2);
        check_eq("tmo_edge_fault", fault, 0);
        cyc();
        check_eq("tmo_fault_state", seq_state, 5);
        check_eq("tmo_fault", fault, 1);
        check_eq("tmo_led0", status_led, 3);
        check_eq("tmo_qsys", qsys_reset_n, 1);
        check_eq("tmo_fab", fabric_reset, 1);
        repeat (3) cyc();
        check_eq("blink_a", status_led, 3);
        cyc();
        check_eq("blink_b", status_led, 0);
        repeat (3) cyc();
        check_eq("blink_c", status_led, 0);
        cyc();
        check_eq("blink_d", status_led, 3);
        check_eq("fault_sticky", fault, 1);

        // ninit pulse clears FAULT
        ninit_done_ninit_done = 1'b1;
        cyc();
        ninit_done_ninit_done = 1'b0;
        cyc();
        check_eq("ninit_sync", seq_state, 5);
        cyc();
        check_reset_vals("ninit_cfg");
        cyc();
        check_eq("ninit_hold", seq_state, 1);

        // Block reset in HOLD with cnt=3
        repeat (4) cyc();
        check_eq("hold_mid", seq_state, 1);
        reset_reset = 1'b1;
        cyc();
        check_reset_vals("rst_hold");
        reset_reset = 1'b0;
        repeat (2) cyc();
        check_eq("rst_hold_sync", seq_state, 0);
        cyc();
        check_eq("rst_hold_rehold", seq_state, 1);
        wait_state(3'd2, 30, n);
        check_eq("rst_hold_len", n, 8);
        wait_state(3'd5, 100, n);
        check_eq("rst_tmo_len", n, 64);
        check_eq("rst_tmo_fault", fault, 1);

        // Block reset in FAULT, then clean bring-up
        reset_reset = 1'b1;
        cyc();
        check_reset_vals("rst_fault");
        reset_reset     = 1'b0;
        h2f_reset_reset = 1'b0;
        wait_state(3'd3, 40, n);
        check_eq("rebring_len", n, 15);
        check_eq("rebring_fault", fault, 0);
        check_eq("rebring_fab", fabric_reset, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
